// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32 constants and the M-extension op encodings
//
// Holds XLEN, the funct3 encodings of the M-extension ops, and the opcode/funct7
// values the decoder uses to route M-ops to muldiv_seq instead of the ALU.
// Also holds the muldiv_seq FSM state type.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } muldiv_state_e;

  // True when an R-type instruction belongs to the multiply/divide unit.
  function automatic logic is_muldiv(input logic [6:0] opcode, input logic [6:0] funct7);
    return (opcode == OPCODE_OP) && (funct7 == FUNCT7_MULDIV);
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative RV32M multiply/divide sequencer
//
// One M-op at a time: radix-2 shift-add multiply or restoring divide on operand
// magnitudes, followed by a sign fixup and a one-cycle done pulse. Holds the
// pipeline through stall while the op is running.
//
// Ports:
//   clk     in   1     clock, rising edge
//   rst_n   in   1     asynchronous active-low reset
//   start   in   1     valid M-op present in EX (only looked at in IDLE)
//   funct3  in   3     M-op select (mul/mulh/mulhsu/mulhu/div/divu/rem/remu)
//   op_a    in   XLEN  rs1 value, sampled with start
//   op_b    in   XLEN  rs2 value, sampled with start
//   flush   in   1     abort the current op, return to IDLE without done
//   busy    out  1     op in progress (CALC or FIXUP)
//   stall   out  1     freeze IF/ID/EX
//   done    out  1     one-cycle pulse, result valid
//   result  out  XLEN  last completed result, held until the next done
module muldiv_seq
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

  muldiv_state_e   state;
  logic [CNT_W-1:0] count;
  // mul: {product high, product low / remaining multiplier bits}
  // div: {partial remainder, dividend bits shifting out / quotient bits shifting in}
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;      // multiplicand magnitude (mul) or divisor magnitude (div)
  logic              neg;       // result must be negated in FIXUP
  logic              is_div;
  logic              sel_hi;    // mulh* : return upper product half
  logic              sel_rem;   // rem*  : return remainder

  // ---------------------------------------------------------------- decode
  logic a_signed, b_signed, dec_div, dec_hi, dec_rem;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    dec_div  = 1'b0;
    dec_hi   = 1'b0;
    dec_rem  = 1'b0;
    case (muldiv_op_e'(funct3))
      MD_MUL:    begin a_signed = 1'b1; b_signed = 1'b1; end
      MD_MULH:   begin a_signed = 1'b1; b_signed = 1'b1; dec_hi = 1'b1; end
      MD_MULHSU: begin a_signed = 1'b1; dec_hi = 1'b1; end
      MD_MULHU:  begin dec_hi = 1'b1; end
      MD_DIV:    begin a_signed = 1'b1; b_signed = 1'b1; dec_div = 1'b1; end
      MD_DIVU:   begin dec_div = 1'b1; end
      MD_REM:    begin a_signed = 1'b1; b_signed = 1'b1; dec_div = 1'b1; dec_rem = 1'b1; end
      MD_REMU:   begin dec_div = 1'b1; dec_rem = 1'b1; end
      default:   ;
    endcase
  end

  logic            sa, sb;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            start_neg;
  logic            b_zero, div_ovf, special;
  logic [XLEN-1:0] special_val;

  assign sa        = a_signed & op_a[XLEN-1];
  assign sb        = b_signed & op_b[XLEN-1];
  assign a_mag     = sa ? -op_a : op_a;
  assign b_mag     = sb ? -op_b : op_b;
  // Remainder takes the dividend's sign; everything else the product/quotient sign.
  assign start_neg = dec_rem ? sa : (sa ^ sb);

  assign b_zero  = (op_b == '0);
  // Signed overflow: most-negative / -1. Only the signed divide/remainder ops see it.
  assign div_ovf = dec_div & a_signed
                 & (op_a == {1'b1, {(XLEN-1){1'b0}}})
                 & (op_b == {XLEN{1'b1}});
  assign special = dec_div & (b_zero | div_ovf);

  always_comb begin
    special_val = '0;
    if (b_zero)
      special_val = dec_rem ? op_a : {XLEN{1'b1}};
    else
      special_val = dec_rem ? '0 : op_a;
  end

  // ----------------------------------------------------------- loop datapath
  logic [XLEN:0]     add_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     shifted;
  logic [XLEN:0]     diff;
  logic              ge;
  logic [2*XLEN-1:0] div_next;

  assign add_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
  assign mul_next = acc[0] ? {add_sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};

  assign shifted  = acc[2*XLEN-1:XLEN-1];
  assign diff     = shifted - {1'b0, opnd};
  // A set top bit in the shifted remainder already exceeds any XLEN-bit divisor,
  // so the trial subtract cannot go negative in that case.
  assign ge       = shifted[XLEN] | ~diff[XLEN];
  assign div_next = {(ge ? diff[XLEN-1:0] : shifted[XLEN-1:0]), acc[XLEN-2:0], ge};

  // ----------------------------------------------------------------- fixup
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_val;

  assign prod_fix = neg ? -acc : acc;
  assign quot_fix = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem_fix  = neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  always_comb begin
    fix_val = '0;
    if (is_div)
      fix_val = sel_rem ? rem_fix : quot_fix;
    else
      fix_val = sel_hi ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
  end

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      count   <= '0;
      acc     <= '0;
      opnd    <= '0;
      neg     <= 1'b0;
      is_div  <= 1'b0;
      sel_hi  <= 1'b0;
      sel_rem <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else if (flush) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            count   <= '0;
            neg     <= start_neg;
            is_div  <= dec_div;
            sel_hi  <= dec_hi;
            sel_rem <= dec_rem;
            if (dec_div) begin
              acc  <= {{XLEN{1'b0}}, a_mag};
              opnd <= b_mag;
            end else begin
              acc  <= {{XLEN{1'b0}}, b_mag};
              opnd <= a_mag;
            end
            if (special) begin
              result <= special_val;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              busy  <= 1'b1;
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc <= is_div ? div_next : mul_next;
          if (count == LAST_ITER)
            state <= S_FIXUP;
          else
            count <= count + 1'b1;
        end
        S_FIXUP: begin
          result <= fix_val;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign stall = (start & (state == S_IDLE) & ~flush) | busy;

endmodule
